// File: rtl/mem_pkg.sv
// Shared definitions for the unified instruction/data memory responder.
//  - bus_cmd_t    : bus command encoding used by both memory ports
//  - dmem_state_t : states of the data-port request sequencer
//  - NOOP_INST    : word returned by the fetch port when nothing valid is fetched
//  - addr_ok      : aligned and in-range check for a byte address
//  - sat_inc      : saturating 32-bit increment for the optional access counters
package mem_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  // A byte address is usable when it is word aligned and below the array size in bytes.
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : (value + 32'd1);
  endfunction

endpackage

// File: rtl/dmem_req_fsm.sv
// Data-port request sequencer for dual_port_mem_responder.
// Owns the request latch, the latency counter, busy/err generation and the
// read/write strobes into the shared array held by the top level.
// Ports:
//  clk, rst                 clock, asynchronous active-high reset
//  req_addr/req_cmd/req_data  data-port request from the core
//  busy                     request accepted, response not yet given
//  err                      response cycle of a misaligned/out-of-range access
//  rd_en / wr_en            array read / write strobe for the response cycle
//  acc_idx / acc_data       word index and store data of the access being served
//  load_done / store_done   completion pulses (only with MEM_ACCESS_COUNT_EN)
// With DMEM_LATENCY == 0 the request is served straight from the bus and the
// sequencer never leaves IDLE.
module dmem_req_fsm
  import mem_pkg::*;
#(
  parameter int          DMEM_LATENCY = 0,
  parameter int          IDX_W        = 12,
  parameter logic [31:0] BYTE_LIMIT   = 32'd16384
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      req_addr,
  input  logic [1:0]       req_cmd,
  input  logic [31:0]      req_data,
  output logic             busy,
  output logic             err,
  output logic             rd_en,
  output logic             wr_en,
  output logic [IDX_W-1:0] acc_idx,
  output logic [31:0]      acc_data
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic             load_done,
  output logic             store_done
`endif
);

  localparam bit          COMB     = (DMEM_LATENCY == 0);
  localparam bit          MULTI    = (DMEM_LATENCY > 1);
  localparam logic [15:0] CNT_INIT = (DMEM_LATENCY > 0) ? 16'(DMEM_LATENCY - 1) : 16'd0;

  dmem_state_t state_r;
  dmem_state_t state_nx_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_nx_s;
  logic        capture_s;
  logic [31:0] lat_addr_r;
  logic [1:0]  lat_cmd_r;
  logic [31:0] lat_data_r;
  logic        resp_s;
  logic [1:0]  cmd_s;
  logic [31:0] acc_addr_s;
  logic        ok_s;

  // Next-state and latency counter; anything on the bus outside IDLE is ignored.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!COMB && (req_cmd != BUS_NONE)) begin
          capture_s  = 1'b1;
          cnt_nx_s   = CNT_INIT;
          state_nx_s = MULTI ? WAIT : RESP;
        end else begin
          state_nx_s = IDLE;
        end
      end
      WAIT: begin
        cnt_nx_s = cnt_r - 16'd1;
        if (cnt_r == 16'd1) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      RESP: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 16'd0;
      end
      default: begin
        state_nx_s = IDLE;
        cnt_nx_s   = 16'd0;
      end
    endcase
  end

  // State, counter and request latch; reset drops any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 16'd0;
      lat_addr_r <= 32'd0;
      lat_cmd_r  <= 2'd0;
      lat_data_r <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (capture_s) begin
        lat_addr_r <= req_addr;
        lat_cmd_r  <= req_cmd;
        lat_data_r <= req_data;
      end else begin
        lat_addr_r <= lat_addr_r;
        lat_cmd_r  <= lat_cmd_r;
        lat_data_r <= lat_data_r;
      end
    end
  end

  // Response selection: live bus when combinational, latched request otherwise.
  always_comb begin
    resp_s     = COMB ? (req_cmd != BUS_NONE) : (state_r == RESP);
    cmd_s      = COMB ? req_cmd : lat_cmd_r;
    acc_addr_s = COMB ? req_addr : lat_addr_r;
    acc_data   = COMB ? req_data : lat_data_r;
    acc_idx    = acc_addr_s[IDX_W+1:2];
    ok_s       = addr_ok(acc_addr_s, BYTE_LIMIT);
    busy       = 1'b0;
    err        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    if (rst) begin
      busy  = 1'b0;
      err   = 1'b0;
      rd_en = 1'b0;
      wr_en = 1'b0;
    end else begin
      busy  = !COMB && (((state_r == IDLE) && (req_cmd != BUS_NONE)) || (state_r == WAIT));
      rd_en = resp_s && (cmd_s == BUS_LOAD) && ok_s;
      wr_en = resp_s && (cmd_s == BUS_STORE) && ok_s;
      err   = resp_s && ((cmd_s == BUS_LOAD) || (cmd_s == BUS_STORE)) && !ok_s;
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Completion pulses count bad accesses too, so they ignore the range check.
  assign load_done  = !rst && resp_s && (cmd_s == BUS_LOAD);
  assign store_done = !rst && resp_s && (cmd_s == BUS_STORE);
`endif

endmodule

// File: rtl/dual_port_mem_responder.sv
// Unified instruction/data memory responder for testbench and FPGA builds.
// One word array is shared by a combinational fetch port and a data port with
// programmable latency (sequenced by dmem_req_fsm).
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  pc_addr, im_command fetch byte address / command; instruction is the fetched word
//  proc2Dmem_addr, proc2Dmem_command, proc2mem_data   data-port request
//  mem2proc_data       load data in the response cycle, 0 otherwise
//  dmem_busy           request accepted, response pending (core holds its request)
//  dmem_err            response cycle of a misaligned or out-of-range access
//  fetch_count, load_count, store_count   saturating access counters,
//                      present only when MEM_ACCESS_COUNT_EN is defined
// Array contents are never cleared by rst.
module dual_port_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 4096,
  parameter int DMEM_LATENCY = 0,
  parameter     INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic [1:0]  im_command,
  output logic [31:0] instruction,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2mem_data,
  output logic [31:0] mem2proc_data,
  output logic        dmem_busy,
  output logic        dmem_err
`ifdef MEM_ACCESS_COUNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] load_count,
  output logic [31:0] store_count
`endif
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0]      mem_r [DEPTH_WORDS];
  logic             rd_en_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic [31:0]      acc_data_s;
`ifdef MEM_ACCESS_COUNT_EN
  logic             load_done_s;
  logic             store_done_s;
`endif

  dmem_req_fsm #(
    .DMEM_LATENCY (DMEM_LATENCY),
    .IDX_W        (IDX_W),
    .BYTE_LIMIT   (BYTE_LIMIT)
  ) u_req_fsm (
    .clk      (clk),
    .rst      (rst),
    .req_addr (proc2Dmem_addr),
    .req_cmd  (proc2Dmem_command),
    .req_data (proc2mem_data),
    .busy     (dmem_busy),
    .err      (dmem_err),
    .rd_en    (rd_en_s),
    .wr_en    (wr_en_s),
    .acc_idx  (acc_idx_s),
    .acc_data (acc_data_s)
`ifdef MEM_ACCESS_COUNT_EN
    ,
    .load_done  (load_done_s),
    .store_done (store_done_s)
`endif
  );

  // Data-port write; a same-cycle fetch of this word still sees the old value.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[acc_idx_s] <= acc_data_s;
    end
  end

  // Fetch port: never stalls, NOOP for idle, bad or in-reset fetches.
  always_comb begin
    if (!rst && (im_command == BUS_LOAD) && addr_ok(pc_addr, BYTE_LIMIT)) begin
      instruction = mem_r[pc_addr[IDX_W+1:2]];
    end else begin
      instruction = NOOP_INST;
    end
  end

  // Load data is driven only during a good load response.
  always_comb begin
    if (rd_en_s) begin
      mem2proc_data = mem_r[acc_idx_s];
    end else begin
      mem2proc_data = 32'd0;
    end
  end

`ifdef MEM_ACCESS_COUNT_EN
  // Saturating access counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= 32'd0;
      load_count  <= 32'd0;
      store_count <= 32'd0;
    end else begin
      fetch_count <= (im_command == BUS_LOAD) ? sat_inc(fetch_count) : fetch_count;
      load_count  <= load_done_s  ? sat_inc(load_count)  : load_count;
      store_count <= store_done_s ? sat_inc(store_count) : store_count;
    end
  end
`endif

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Self-checking bench for dual_port_mem_responder. Four instances with data
// latencies 0, 2, 3 and 4 share clock and reset; each has its own bus inputs.
// A transaction-level model (array + one pending request with a due cycle)
// is compared against every instance at each falling edge; directed steps add
// hand-computed literal expectations.
module tb_dual_port_mem_responder;

  localparam int          NI    = 4;
  localparam int          DEPTH = 256;
  localparam logic [31:0] NOOP  = 32'h0000_0013;
  localparam logic [1:0]  C_NONE  = 2'd0;
  localparam logic [1:0]  C_LOAD  = 2'd1;
  localparam logic [1:0]  C_STORE = 2'd2;

  function automatic int lat_of(input int g);
    return (g == 0) ? 0 : (g == 1) ? 2 : (g == 2) ? 3 : 4;
  endfunction

  logic        clk;
  logic        rst;
  logic [31:0] pc_addr [NI];
  logic [1:0]  im_cmd  [NI];
  logic [31:0] d_addr  [NI];
  logic [1:0]  d_cmd   [NI];
  logic [31:0] wdata   [NI];
  logic [31:0] instr   [NI];
  logic [31:0] rdata   [NI];
  logic        busy    [NI];
  logic        err     [NI];
`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] fcnt [NI];
  logic [31:0] lcnt [NI];
  logic [31:0] scnt [NI];
`endif

  int n_checks = 0;
  int n_err    = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dual_port_mem_responder #(
      .DEPTH_WORDS  (DEPTH),
      .DMEM_LATENCY (lat_of(g)),
      .INIT_FILE    ("")
    ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .pc_addr           (pc_addr[g]),
      .im_command        (im_cmd[g]),
      .instruction       (instr[g]),
      .proc2Dmem_addr    (d_addr[g]),
      .proc2Dmem_command (d_cmd[g]),
      .proc2mem_data     (wdata[g]),
      .mem2proc_data     (rdata[g]),
      .dmem_busy         (busy[g]),
      .dmem_err          (err[g])
`ifdef MEM_ACCESS_COUNT_EN
      ,
      .fetch_count       (fcnt[g]),
      .load_count        (lcnt[g]),
      .store_count       (scnt[g])
`endif
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, expected the bench to end earlier");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [NI][DEPTH];
  bit          m_known [NI][DEPTH];
  bit          p_valid [NI];
  logic [1:0]  p_cmd   [NI];
  logic [31:0] p_addr  [NI];
  logic [31:0] p_data  [NI];
  int          p_due   [NI];
  int          cyc = 0;
`ifdef MEM_ACCESS_COUNT_EN
  logic [31:0] mf [NI];
  logic [31:0] ml [NI];
  logic [31:0] ms [NI];
`endif

  function automatic bit good(input logic [31:0] a);
    return (a % 32'd4 == 32'd0) && (a < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(a / 32'd4);
  endfunction

  initial begin
    for (int g = 0; g < NI; g++) begin
      p_valid[g] = 1'b0;
      for (int w = 0; w < DEPTH; w++) m_known[g][w] = 1'b0;
    end
  end

  always @(negedge clk) begin : model_cmp
    for (int g = 0; g < NI; g++) begin
      logic [31:0] e_ins, e_rd, s_addr, s_data;
      logic [1:0]  s_cmd;
      bit          e_busy, e_err, kn_i, kn_d, serve, do_wr;
      e_ins = NOOP; e_rd = 32'd0; e_busy = 1'b0; e_err = 1'b0;
      kn_i = 1'b1; kn_d = 1'b1; serve = 1'b0; do_wr = 1'b0;
      s_cmd = C_NONE; s_addr = 32'd0; s_data = 32'd0;
      if (rst) begin
        p_valid[g] = 1'b0;
`ifdef MEM_ACCESS_COUNT_EN
        mf[g] = 32'd0; ml[g] = 32'd0; ms[g] = 32'd0;
`endif
      end else begin
        if (im_cmd[g] == C_LOAD && good(pc_addr[g])) begin
          e_ins = m_mem[g][widx(pc_addr[g])];
          kn_i  = m_known[g][widx(pc_addr[g])];
        end
        if (lat_of(g) == 0) begin
          serve = (d_cmd[g] != C_NONE);
          s_cmd = d_cmd[g]; s_addr = d_addr[g]; s_data = wdata[g];
        end else if (p_valid[g] && cyc == p_due[g]) begin
          serve = 1'b1;
          s_cmd = p_cmd[g]; s_addr = p_addr[g]; s_data = p_data[g];
          p_valid[g] = 1'b0;
        end else if (p_valid[g]) begin
          e_busy = 1'b1;
        end else if (d_cmd[g] != C_NONE) begin
          e_busy = 1'b1;
          p_valid[g] = 1'b1;
          p_cmd[g] = d_cmd[g]; p_addr[g] = d_addr[g]; p_data[g] = wdata[g];
          p_due[g] = cyc + lat_of(g);
        end
        if (serve && s_cmd == C_LOAD) begin
          if (good(s_addr)) begin
            e_rd = m_mem[g][widx(s_addr)];
            kn_d = m_known[g][widx(s_addr)];
          end else begin
            e_err = 1'b1;
          end
        end else if (serve && s_cmd == C_STORE) begin
          if (good(s_addr)) do_wr = 1'b1;
          else              e_err = 1'b1;
        end
      end
      if (kn_i) chk($sformatf("u%0d.instruction", g), instr[g], e_ins);
      if (kn_d) chk($sformatf("u%0d.mem2proc_data", g), rdata[g], e_rd);
      chk($sformatf("u%0d.dmem_busy", g), 32'(busy[g]), 32'(e_busy));
      chk($sformatf("u%0d.dmem_err", g), 32'(err[g]), 32'(e_err));
`ifdef MEM_ACCESS_COUNT_EN
      chk($sformatf("u%0d.fetch_count", g), fcnt[g], mf[g]);
      chk($sformatf("u%0d.load_count", g), lcnt[g], ml[g]);
      chk($sformatf("u%0d.store_count", g), scnt[g], ms[g]);
      if (!rst) begin
        if (im_cmd[g] == C_LOAD && mf[g] != 32'hFFFF_FFFF) mf[g] = mf[g] + 32'd1;
        if (serve && s_cmd == C_LOAD && ml[g] != 32'hFFFF_FFFF) ml[g] = ml[g] + 32'd1;
        if (serve && s_cmd == C_STORE && ms[g] != 32'hFFFF_FFFF) ms[g] = ms[g] + 32'd1;
      end
`endif
      if (do_wr) begin
        m_mem[g][widx(s_addr)]   = s_data;
        m_known[g][widx(s_addr)] = 1'b1;
      end
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int g = 0; g < NI; g++) begin
      im_cmd[g] = C_NONE; pc_addr[g] = 32'd0;
      d_cmd[g]  = C_NONE; d_addr[g]  = 32'd0; wdata[g] = 32'd0;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    for (int g = 0; g < NI; g++) begin
      d_cmd[g] = C_STORE; d_addr[g] = a; wdata[g] = d;
    end
    repeat (5) tick();
    idle_all();
    repeat (5) tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    idle_all();
    im_cmd[0] = C_LOAD;           // fetch while in reset must still give NOOP
    d_cmd[3]  = C_LOAD;           // request while in reset must not raise busy
    #2 rst = 1'b1;
    at_neg();
    chk("reset.instruction", instr[0], 32'h0000_0013);
    chk("reset.mem2proc_data", rdata[0], 32'h0000_0000);
    chk("reset.busy", 32'(busy[3]), 32'd0);
    chk("reset.err", 32'(err[3]), 32'd0);
    tick();
    rst = 1'b0;
    idle_all();
    tick();

    preload(32'h000, 32'h00C0_FFEE);
    preload(32'h008, 32'h1111_0008);
    preload(32'h00C, 32'h2222_000C);
    preload(32'h040, 32'h1234_5678);
    preload(32'h100, 32'hC0DE_0100);

    // latency 0: store then load next cycle; same-cycle fetch sees old word
    d_cmd[0] = C_STORE; d_addr[0] = 32'h100; wdata[0] = 32'hDEAD_BEEF;
    im_cmd[0] = C_LOAD; pc_addr[0] = 32'h100;
    at_neg();
    chk("lat0.fetch_old", instr[0], 32'hC0DE_0100);
    chk("lat0.store_busy", 32'(busy[0]), 32'd0);
    tick();
    d_cmd[0] = C_LOAD;
    at_neg();
    chk("lat0.load_data", rdata[0], 32'hDEAD_BEEF);
    chk("lat0.load_busy", 32'(busy[0]), 32'd0);
    chk("lat0.fetch_new", instr[0], 32'hDEAD_BEEF);
    tick();

    // latency 0: bad accesses
    im_cmd[0] = C_NONE;
    d_cmd[0] = C_LOAD; d_addr[0] = 32'h102;
    at_neg();
    chk("bad.load_data", rdata[0], 32'd0);
    chk("bad.load_err", 32'(err[0]), 32'd1);
    tick();
    d_cmd[0] = C_STORE; d_addr[0] = 32'h400; wdata[0] = 32'hFFFF_FFFF;
    at_neg();
    chk("bad.store_err", 32'(err[0]), 32'd1);
    tick();
    idle_all();
    im_cmd[0] = C_LOAD; pc_addr[0] = 32'h000;
    at_neg();
    chk("bad.store_dropped", instr[0], 32'h00C0_FFEE);
    tick();
    im_cmd[0] = C_NONE;
    at_neg();
    chk("fetch.none", instr[0], 32'h0000_0013);
    tick();
    im_cmd[0] = C_LOAD; pc_addr[0] = 32'h002;
    at_neg();
    chk("fetch.misaligned", instr[0], 32'h0000_0013);
    tick();
    pc_addr[0] = 32'h400;
    at_neg();
    chk("fetch.out_of_range", instr[0], 32'h0000_0013);
    tick();
    idle_all();

    // latency 3: load @0x40
    d_cmd[2] = C_LOAD; d_addr[2] = 32'h040;
    at_neg();
    chk("lat3.busy_t0", 32'(busy[2]), 32'd1);
    chk("lat3.data_t0", rdata[2], 32'd0);
    tick(); at_neg();
    chk("lat3.busy_t1", 32'(busy[2]), 32'd1);
    tick(); at_neg();
    chk("lat3.busy_t2", 32'(busy[2]), 32'd1);
    tick(); at_neg();
    chk("lat3.data_t3", rdata[2], 32'h1234_5678);
    chk("lat3.busy_t3", 32'(busy[2]), 32'd0);
    tick();
    idle_all();
    // latency 3: misaligned load reports error only in its response cycle
    d_cmd[2] = C_LOAD; d_addr[2] = 32'h102;
    repeat (3) tick();
    at_neg();
    chk("lat3.bad_err", 32'(err[2]), 32'd1);
    chk("lat3.bad_data", rdata[2], 32'd0);
    tick();
    idle_all();
    tick();

    // latency 2: address changes during WAIT are ignored
    d_cmd[1] = C_STORE; d_addr[1] = 32'h008; wdata[1] = 32'h55AA_55AA;
    at_neg();
    chk("lat2.busy_t0", 32'(busy[1]), 32'd1);
    tick();
    d_addr[1] = 32'h00C;
    at_neg();
    chk("lat2.busy_t1", 32'(busy[1]), 32'd1);
    tick(); at_neg();
    chk("lat2.busy_t2", 32'(busy[1]), 32'd0);
    tick();
    idle_all();
    im_cmd[1] = C_LOAD; pc_addr[1] = 32'h008;
    at_neg();
    chk("lat2.word8", instr[1], 32'h55AA_55AA);
    tick();
    pc_addr[1] = 32'h00C;
    at_neg();
    chk("lat2.wordC", instr[1], 32'h2222_000C);
    tick();
    idle_all();

    // latency 4: reset during WAIT drops the pending store
    d_cmd[3] = C_STORE; d_addr[3] = 32'h040; wdata[3] = 32'h9999_9999;
    tick(); tick();
    rst = 1'b1;
    at_neg();
    chk("lat4.rst_busy", 32'(busy[3]), 32'd0);
    chk("lat4.rst_err", 32'(err[3]), 32'd0);
    tick();
    rst = 1'b0;
    idle_all();
    repeat (5) tick();
    im_cmd[3] = C_LOAD; pc_addr[3] = 32'h040;
    at_neg();
    chk("lat4.word_unchanged", instr[3], 32'h1234_5678);
    tick();
    idle_all();

`ifdef MEM_ACCESS_COUNT_EN
    // counters: 5 fetches, 2 loads, 1 store on the latency-0 instance
    rst = 1'b1;
    at_neg();
    chk("cnt.rst_fetch", fcnt[0], 32'd0);
    chk("cnt.rst_load", lcnt[0], 32'd0);
    chk("cnt.rst_store", scnt[0], 32'd0);
    tick();
    rst = 1'b0;
    im_cmd[0] = C_LOAD; pc_addr[0] = 32'h040;
    repeat (5) tick();
    im_cmd[0] = C_NONE;
    d_cmd[0] = C_LOAD; d_addr[0] = 32'h040;
    repeat (2) tick();
    d_cmd[0] = C_STORE; d_addr[0] = 32'h3FC; wdata[0] = 32'h0000_0001;
    tick();
    idle_all();
    at_neg();
    chk("cnt.fetch", fcnt[0], 32'd5);
    chk("cnt.load", lcnt[0], 32'd2);
    chk("cnt.store", scnt[0], 32'd1);
    tick();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
